// File: rtl/systolic_input_skewer.sv
// ---------------------------------------------------------------------------
// systolic_input_skewer
//
// Left-edge feeder for the PE systolic array. One NUM_LANES-wide row vector
// is accepted per cycle; lane k leaves the block k+1 cycles later, which
// produces the diagonal wavefront each PE row expects. After the last vector
// of a tile the block holds s_ready_o low until the skew has drained, then
// pulses tile_done_o in the same cycle the last element leaves the top lane.
//
// Build option:
//   SKEW_ZERO_FILL_EN  defined   -> bubble cycles present 0 on lane_data_o
//                      undefined -> bubble data is whatever s_data_i held
//
// Ports:
//   clk_i         clock
//   rst_i         asynchronous reset, active high
//   s_data_i      row vector, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   s_valid_i     s_data_i valid
//   s_last_i      last vector of tile, qualified by s_valid_i
//   s_ready_o     skewer can accept this cycle
//   lane_data_o   skewed data, lane k feeds PE row k
//   lane_valid_o  skewed valid per lane
//   tile_done_o   one-cycle pulse, last element leaving lane NUM_LANES-1
//   vec_count_o   vectors accepted in the current tile (saturating)
//   overflow_o    sticky: more than MAX_TILE_VECS accepted without a last
//
// FSM states:
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | no tile open, ready to accept
//   ST_STREAM | tile open, accepting vectors
//   ST_FLUSH  | last vector taken, ready low while the skew drains
// ---------------------------------------------------------------------------
module systolic_input_skewer #(
  parameter int NUM_LANES     = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_TILE_VECS = 256
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]      s_data_i,
  input  logic                                 s_valid_i,
  input  logic                                 s_last_i,
  output logic                                 s_ready_o,
  output logic [NUM_LANES*DATA_WIDTH-1:0]      lane_data_o,
  output logic [NUM_LANES-1:0]                 lane_valid_o,
  output logic                                 tile_done_o,
  output logic [$clog2(MAX_TILE_VECS+1)-1:0]   vec_count_o,
  output logic                                 overflow_o
);

  localparam int CNT_W = $clog2(MAX_TILE_VECS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TILE_VECS);

  // The flush counter must hold NUM_LANES-2; keep at least one bit so the
  // declaration stays legal for the 1- and 2-lane builds.
  localparam int FLUSH_W = (NUM_LANES > 2) ? $clog2(NUM_LANES - 1) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LOAD =
    FLUSH_W'((NUM_LANES > 1) ? (NUM_LANES - 2) : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]     vec_count_q, vec_count_d;
  logic [CNT_W-1:0]     cnt_base;
  logic                 overflow_q, overflow_d;
  logic [NUM_LANES-1:0] done_q;
  logic                 ready;
  logic                 accept;

  assign ready  = (state_q != ST_FLUSH);
  assign accept = s_valid_i & ready;

  // -------------------------------------------------------------------------
  // Sequencing FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_IDLE, ST_STREAM: begin
        if (accept) begin
          if (s_last_i) begin
            // A single lane has no skew to drain.
            if (NUM_LANES == 1) begin
              state_d = ST_IDLE;
            end else begin
              state_d     = ST_FLUSH;
              flush_cnt_d = FLUSH_LOAD;
            end
          end else begin
            state_d = ST_STREAM;
          end
        end
      end
      ST_FLUSH: begin
        // Loaded with NUM_LANES-2 so ready stays low for NUM_LANES-1 cycles.
        if (flush_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Per-lane delay chains: lane k has k+1 stages of data and valid.
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_in;
    logic [DATA_WIDTH-1:0] data_q [k+1];
    logic [k:0]            valid_q;

`ifdef SKEW_ZERO_FILL_EN
    // Zeroing at the chain input keeps bubbles zero all the way down while
    // the output stays a plain register.
    assign lane_in = accept ? s_data_i[k*DATA_WIDTH +: DATA_WIDTH] : '0;
`else
    assign lane_in = s_data_i[k*DATA_WIDTH +: DATA_WIDTH];
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i <= k; i++) begin
          data_q[i] <= '0;
        end
        valid_q <= '0;
      end else begin
        data_q[0]  <= lane_in;
        valid_q[0] <= accept;
        for (int i = 1; i <= k; i++) begin
          data_q[i]  <= data_q[i-1];
          valid_q[i] <= valid_q[i-1];
        end
      end
    end

    assign lane_data_o[k*DATA_WIDTH +: DATA_WIDTH] = data_q[k];
    assign lane_valid_o[k]                         = valid_q[k];
  end

  // -------------------------------------------------------------------------
  // Tile-done marker travels alongside the top lane so the pulse lines up
  // exactly with the last element leaving lane NUM_LANES-1.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q <= '0;
    end else begin
      done_q[0] <= accept & s_last_i;
      for (int i = 1; i < NUM_LANES; i++) begin
        done_q[i] <= done_q[i-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Vector count and overflow
  // -------------------------------------------------------------------------
  // During the done pulse the held count belongs to the finished tile; an
  // accept in that cycle opens the next tile and is counted from zero, and
  // must not be judged against the old tile's count for overflow.
  assign cnt_base = done_q[NUM_LANES-1] ? '0 : vec_count_q;

  always_comb begin
    vec_count_d = cnt_base;
    if (accept && (cnt_base != CNT_MAX)) begin
      vec_count_d = cnt_base + 1'b1;
    end
    overflow_d = overflow_q | (accept & ~s_last_i & (cnt_base == CNT_MAX));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vec_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      vec_count_q <= vec_count_d;
      overflow_q  <= overflow_d;
    end
  end

  assign s_ready_o   = ready;
  assign tile_done_o = done_q[NUM_LANES-1];
  assign vec_count_o = vec_count_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Self-checking bench for systolic_input_skewer (4 lanes, 32-bit, 8 vecs).
// A cycle-indexed history of accepted vectors is the reference: lane k at
// cycle c shows whatever was accepted at cycle c-k-1.
module tb_systolic_input_skewer;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int MAX  = 8;
  localparam int CW   = $clog2(MAX + 1);
  localparam int HMAX = 4096;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N*DW-1:0] s_data_i;
  logic            s_valid_i;
  logic            s_last_i;
  logic            s_ready_o;
  logic [N*DW-1:0] lane_data_o;
  logic [N-1:0]    lane_valid_o;
  logic            tile_done_o;
  logic [CW-1:0]   vec_count_o;
  logic            overflow_o;

  always #5 clk_i = ~clk_i;

  systolic_input_skewer #(
    .NUM_LANES    (N),
    .DATA_WIDTH   (DW),
    .MAX_TILE_VECS(MAX)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .s_data_i    (s_data_i),
    .s_valid_i   (s_valid_i),
    .s_last_i    (s_last_i),
    .s_ready_o   (s_ready_o),
    .lane_data_o (lane_data_o),
    .lane_valid_o(lane_valid_o),
    .tile_done_o (tile_done_o),
    .vec_count_o (vec_count_o),
    .overflow_o  (overflow_o)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  int              cyc   = 0;
  int              base  = 0;
  int              m_cnt = 0;
  bit              m_ovf = 1'b0;
  bit              h_acc  [HMAX];
  bit              h_lacc [HMAX];
  logic [N*DW-1:0] h_data [HMAX];

  typedef struct {
    bit          v;
    bit          l;
    logic [31:0] b;
    bit          e_rdy;
    bit          e_done;
    int          e_cnt;
    logic [3:0]  e_lv;
  } vec_t;

  vec_t tbl [17];

  function automatic bit acc_at(int c);
    return (c >= base) ? h_acc[c] : 1'b0;
  endfunction

  function automatic bit lacc_at(int c);
    return (c >= base) ? h_lacc[c] : 1'b0;
  endfunction

  function automatic logic [N*DW-1:0] data_at(int c);
    return (c >= base) ? h_data[c] : '0;
  endfunction

  function automatic logic [N*DW-1:0] mkvec(logic [31:0] b);
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = b + DW'(k);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] rndvec();
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = $urandom;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Called at a negedge: compare outputs with the model, drive this cycle's
  // inputs, advance the model, and return at the next negedge.
  task automatic step(input bit v, input bit l, input logic [N*DW-1:0] d);
    logic [N-1:0]    ev;
    logic [N*DW-1:0] ed;
    logic [N*DW-1:0] src;
    bit              rdy;
    bit              dn;
    bit              a;
    int              eff;
    rdy = 1'b1;
    for (int j = 1; j < N; j++) if (lacc_at(cyc - j)) rdy = 1'b0;
    dn = lacc_at(cyc - N);
    for (int k = 0; k < N; k++) begin
      ev[k] = acc_at(cyc - k - 1);
      src   = data_at(cyc - k - 1);
`ifdef SKEW_ZERO_FILL_EN
      ed[k*DW +: DW] = ev[k] ? src[k*DW +: DW] : '0;
`else
      ed[k*DW +: DW] = src[k*DW +: DW];
`endif
    end
    chk("ready",      128'(s_ready_o),    128'(rdy));
    chk("tile_done",  128'(tile_done_o),  128'(dn));
    chk("vec_count",  128'(vec_count_o),  128'(m_cnt));
    chk("overflow",   128'(overflow_o),   128'(m_ovf));
    chk("lane_valid", 128'(lane_valid_o), 128'(ev));
    chk("lane_data",  128'(lane_data_o),  128'(ed));

    s_valid_i = v;
    s_last_i  = l;
    s_data_i  = d;
    a = v & rdy;
    h_acc[cyc]  = a;
    h_lacc[cyc] = a & l;
    h_data[cyc] = d;
    eff = dn ? 0 : m_cnt;
    if (a && !l && eff == MAX) m_ovf = 1'b1;
    if (a) m_cnt = (eff < MAX) ? eff + 1 : MAX;
    else   m_cnt = eff;
    cyc++;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Asserts reset between clock edges, checks the asynchronous clear, and
  // releases at the following negedge.
  task automatic do_reset();
    #2;
    rst_i     = 1'b1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    #1;
    chk("rst_lane_valid", 128'(lane_valid_o), 128'(0));
    chk("rst_tile_done",  128'(tile_done_o),  128'(0));
    chk("rst_vec_count",  128'(vec_count_o),  128'(0));
    chk("rst_overflow",   128'(overflow_o),   128'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    base  = cyc;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  initial begin
    //            v     l     data     rdy   done  cnt  lane_valid
    tbl[0]  = '{1'b1, 1'b1, 32'hA0, 1'b1, 1'b0, 0, 4'b0000};
    tbl[1]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1, 4'b0001};
    tbl[2]  = '{1'b1, 1'b0, 32'hEE, 1'b0, 1'b0, 1, 4'b0010};
    tbl[3]  = '{1'b1, 1'b1, 32'hEF, 1'b0, 1'b0, 1, 4'b0100};
    tbl[4]  = '{1'b0, 1'b1, 32'hF0, 1'b1, 1'b1, 1, 4'b1000};
    tbl[5]  = '{1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 0, 4'b0000};
    tbl[6]  = '{1'b1, 1'b0, 32'h20, 1'b1, 1'b0, 1, 4'b0001};
    tbl[7]  = '{1'b1, 1'b1, 32'h30, 1'b1, 1'b0, 2, 4'b0011};
    tbl[8]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 3, 4'b0111};
    tbl[9]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 3, 4'b1110};
    tbl[10] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 3, 4'b1100};
    tbl[11] = '{1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 3, 4'b1000};
    tbl[12] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1, 4'b0001};
    tbl[13] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1, 4'b0010};
    tbl[14] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1, 4'b0100};
    tbl[15] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1, 4'b1000};
    tbl[16] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 0, 4'b0000};

    rst_i     = 1'b1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    s_data_i  = '0;
    @(negedge clk_i);
    chk("rst_hold_valid", 128'(lane_valid_o), 128'(0));
    rst_i = 1'b0;
    base  = 0;

    // single vector, ignored inputs during flush, back-to-back tiles
    for (int i = 0; i < 17; i++) begin
      chk("tbl_ready",      128'(s_ready_o),    128'(tbl[i].e_rdy));
      chk("tbl_done",       128'(tile_done_o),  128'(tbl[i].e_done));
      chk("tbl_vec_count",  128'(vec_count_o),  128'(tbl[i].e_cnt));
      chk("tbl_lane_valid", 128'(lane_valid_o), 128'(tbl[i].e_lv));
      step(tbl[i].v, tbl[i].l, mkvec(tbl[i].b));
    end

    // valid gap 1,0,1 with last on the third vector
    step(1'b1, 1'b0, mkvec(32'h100));
    step(1'b0, 1'b0, mkvec(32'h5A5A0000));
    step(1'b1, 1'b1, mkvec(32'h300));
    step(1'b0, 1'b0, rndvec());
    chk("gap_l3_first", 128'(lane_valid_o[3]), 128'(1));
    chk("gap_l3_first_data", 128'(lane_data_o[3*DW +: DW]), 128'(32'h103));
    step(1'b0, 1'b0, rndvec());
    chk("gap_l3_bubble", 128'(lane_valid_o[3]), 128'(0));
`ifdef SKEW_ZERO_FILL_EN
    chk("gap_l3_zero", 128'(lane_data_o[3*DW +: DW]), 128'(0));
`endif
    step(1'b0, 1'b0, rndvec());
    chk("gap_l3_second", 128'(lane_valid_o[3]), 128'(1));
    chk("gap_l3_second_data", 128'(lane_data_o[3*DW +: DW]), 128'(32'h303));
    chk("gap_done", 128'(tile_done_o), 128'(1));
    repeat (3) step(1'b0, 1'b0, rndvec());

    // nine vectors without last, then close the tile
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, mkvec(32'h1000 + 32'(i) * 32'h10));
    chk("ovf_set", 128'(overflow_o), 128'(1));
    chk("ovf_cnt_sat", 128'(vec_count_o), 128'(MAX));
    step(1'b1, 1'b1, mkvec(32'h2000));
    repeat (5) step(1'b0, 1'b0, rndvec());
    chk("ovf_sticky", 128'(overflow_o), 128'(1));

    // reset two cycles into a flush
    step(1'b1, 1'b1, mkvec(32'h700));
    step(1'b0, 1'b0, rndvec());
    step(1'b0, 1'b0, rndvec());
    chk("flush_ready_low", 128'(s_ready_o), 128'(0));
    do_reset();
    chk("post_rst_ready", 128'(s_ready_o), 128'(1));
    repeat (6) step(1'b0, 1'b0, rndvec());

    // randomized traffic, with one reset midway
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, rndvec());
    end
    repeat (6) step(1'b0, 1'b0, rndvec());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
